// File: rtl/rob_commit_pkg.sv
// rob_commit_pkg: ROB sizing, entry record and shared opcode constants
package rob_commit_pkg;
  localparam int ROB_DEPTH = 8;
  localparam int ROB_TAG_W = 3;
  localparam int CNT_W = 4;
  localparam int REG_W = 5;
  localparam int OPC_W = 7;
  localparam int PC_W = 7;
  localparam int DATA_W = 32;
  localparam logic [OPC_W-1:0] OPC_LOAD = 7'b0000011;
  localparam logic [OPC_W-1:0] OPC_OPIMM = 7'b0010011;
  localparam logic [OPC_W-1:0] OPC_OP = 7'b0110011;
  typedef struct packed {
    logic busy;
    logic done;
    logic [REG_W-1:0] dest;
    logic [OPC_W-1:0] opcode;
    logic [PC_W-1:0] pc;
    logic [DATA_W-1:0] data;
  } rob_entry_t;
endpackage

// File: rtl/rob_commit_if.sv
// rob_commit_if: dispatch/CDB/operand-lookup/commit bundle; master = dispatch side, slave = ROB
interface rob_commit_if;
  import rob_commit_pkg::*;
  logic alloc_valid;
  logic alloc_ready;
  logic [REG_W-1:0] alloc_dest;
  logic [OPC_W-1:0] alloc_opcode;
  logic [PC_W-1:0] alloc_pc;
  logic [ROB_TAG_W-1:0] alloc_tag;
  logic cdb_valid;
  logic [ROB_TAG_W-1:0] cdb_tag;
  logic [DATA_W-1:0] cdb_data;
  logic [ROB_TAG_W-1:0] rd_tag_a;
  logic [ROB_TAG_W-1:0] rd_tag_b;
  logic rd_ready_a;
  logic rd_ready_b;
  logic [DATA_W-1:0] rd_data_a;
  logic [DATA_W-1:0] rd_data_b;
  logic commit_valid;
  logic [ROB_TAG_W-1:0] commit_tag;
  logic [REG_W-1:0] commit_dest;
  logic [DATA_W-1:0] commit_data;
  logic [OPC_W-1:0] commit_opcode;
  logic [PC_W-1:0] commit_pc;
  logic [CNT_W-1:0] rob_count;
  logic rob_empty;
  modport master (
    output alloc_valid, alloc_dest, alloc_opcode, alloc_pc, cdb_valid, cdb_tag, cdb_data, rd_tag_a, rd_tag_b,
    input alloc_ready, alloc_tag, rd_ready_a, rd_ready_b, rd_data_a, rd_data_b, commit_valid, commit_tag,
    commit_dest, commit_data, commit_opcode, commit_pc, rob_count, rob_empty
  );
  modport slave (
    input alloc_valid, alloc_dest, alloc_opcode, alloc_pc, cdb_valid, cdb_tag, cdb_data, rd_tag_a, rd_tag_b,
    output alloc_ready, alloc_tag, rd_ready_a, rd_ready_b, rd_data_a, rd_data_b, commit_valid, commit_tag,
    commit_dest, commit_data, commit_opcode, commit_pc, rob_count, rob_empty
  );
endinterface

// File: rtl/rob_ptr_ctr.sv
// rob_ptr_ctr: wrapping pointer with increment enable; ports clk1, rst_n, inc_i, ptr_o
module rob_ptr_ctr #(
  parameter int W = 3
) (
  input  logic clk1,
  input  logic rst_n,
  input  logic inc_i,
  output logic [W-1:0] ptr_o
);
  logic [W-1:0] ptr_q;
  always_ff @(posedge clk1 or negedge rst_n)
    if (!rst_n) ptr_q <= '0;
    else if (inc_i) ptr_q <= ptr_q + 1'b1;
  assign ptr_o = ptr_q;
endmodule

// File: rtl/rob_commit.sv
// rob_commit: 8-entry reorder buffer with CDB completion and in-order single retire; ports clk1, rst_n, bus (rob_commit_if.slave); optional ROB_CDB_BYPASS_EN forwards same-cycle CDB to rd ports
module rob_commit
  import rob_commit_pkg::*;
(
  input  logic clk1,
  input  logic rst_n,
  rob_commit_if.slave bus
);
  rob_entry_t ent_q [ROB_DEPTH];
  rob_entry_t ent_d [ROB_DEPTH];
  rob_entry_t cmt_q, cmt_d;
  logic [ROB_TAG_W-1:0] cmt_tag_q, cmt_tag_d;
  logic cmt_valid_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic [ROB_TAG_W-1:0] head, tail;
  logic alloc_fire, commit_fire, cdb_fire;
  assign bus.alloc_ready = count_q < CNT_W'(ROB_DEPTH);
  assign alloc_fire = bus.alloc_valid & bus.alloc_ready;
  // head entry is never busy when empty, so a fresh alloc into it cannot retire on the same edge
  assign commit_fire = ent_q[head].busy & ent_q[head].done;
  assign cdb_fire = bus.cdb_valid & ent_q[bus.cdb_tag].busy & ~ent_q[bus.cdb_tag].done;
  rob_ptr_ctr #(.W(ROB_TAG_W)) u_head (.clk1(clk1), .rst_n(rst_n), .inc_i(commit_fire), .ptr_o(head));
  rob_ptr_ctr #(.W(ROB_TAG_W)) u_tail (.clk1(clk1), .rst_n(rst_n), .inc_i(alloc_fire), .ptr_o(tail));
  always_comb begin
    ent_d = ent_q;
    if (cdb_fire) begin
      ent_d[bus.cdb_tag].done = 1'b1;
      ent_d[bus.cdb_tag].data = bus.cdb_data;
    end
    if (commit_fire) ent_d[head] = '0;
    if (alloc_fire) ent_d[tail] = '{busy: 1'b1, done: 1'b0, dest: bus.alloc_dest, opcode: bus.alloc_opcode,
                                   pc: bus.alloc_pc, data: '0};
    cmt_d = commit_fire ? ent_q[head] : '0;
    cmt_tag_d = commit_fire ? head : '0;
    count_d = count_q + CNT_W'(alloc_fire) - CNT_W'(commit_fire);
  end
  always_ff @(posedge clk1 or negedge rst_n)
    if (!rst_n) begin
      ent_q <= '{default: '0};
      cmt_q <= '0;
      cmt_tag_q <= '0;
      cmt_valid_q <= 1'b0;
      count_q <= '0;
    end else begin
      ent_q <= ent_d;
      cmt_q <= cmt_d;
      cmt_tag_q <= cmt_tag_d;
      cmt_valid_q <= commit_fire;
      count_q <= count_d;
    end
  always_comb begin
    bus.rd_ready_a = ent_q[bus.rd_tag_a].busy & ent_q[bus.rd_tag_a].done;
    bus.rd_ready_b = ent_q[bus.rd_tag_b].busy & ent_q[bus.rd_tag_b].done;
    bus.rd_data_a = bus.rd_ready_a ? ent_q[bus.rd_tag_a].data : '0;
    bus.rd_data_b = bus.rd_ready_b ? ent_q[bus.rd_tag_b].data : '0;
`ifdef ROB_CDB_BYPASS_EN
    // only a CDB that will actually land forwards; a done entry already shows its stored value
    if (cdb_fire && bus.cdb_tag == bus.rd_tag_a) begin
      bus.rd_ready_a = 1'b1;
      bus.rd_data_a = bus.cdb_data;
    end
    if (cdb_fire && bus.cdb_tag == bus.rd_tag_b) begin
      bus.rd_ready_b = 1'b1;
      bus.rd_data_b = bus.cdb_data;
    end
`endif
  end
  assign bus.alloc_tag = tail;
  assign bus.commit_valid = cmt_valid_q;
  assign bus.commit_tag = cmt_tag_q;
  assign bus.commit_dest = cmt_q.dest;
  assign bus.commit_data = cmt_q.data;
  assign bus.commit_opcode = cmt_q.opcode;
  assign bus.commit_pc = cmt_q.pc;
  assign bus.rob_count = count_q;
  assign bus.rob_empty = count_q == '0;
endmodule

// File: tb/tb_rob_commit.sv
// tb_rob_commit: directed plus random stimulus against a program-order queue model of the ROB
module tb_rob_commit;
  logic clk1 = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;
  rob_commit_if bus ();
  rob_commit dut (.clk1(clk1), .rst_n(rst_n), .bus(bus.slave));
  always #5 clk1 = ~clk1;
  int q[$];
  bit busy[8];
  bit done[8];
  logic [31:0] data[8];
  logic [4:0] dest[8];
  logic [6:0] opc[8];
  logic [6:0] pcs[8];
  int nxt;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic model_clear();
    q.delete();
    nxt = 0;
    for (int i = 0; i < 8; i++) begin
      busy[i] = 0;
      done[i] = 0;
    end
  endtask
  task automatic exp_rd(input logic [2:0] t, input bit cv, input logic [2:0] ct, input logic [31:0] cd,
                        output logic rdy, output logic [31:0] dat);
    rdy = busy[t] && done[t];
    dat = rdy ? data[t] : 32'h0;
`ifdef ROB_CDB_BYPASS_EN
    if (cv && ct == t && busy[t] && !done[t]) begin
      rdy = 1'b1;
      dat = cd;
    end
`endif
  endtask
  task automatic cyc(input bit av, input logic [4:0] d, input logic [6:0] op, input logic [6:0] pc,
                     input bit cv, input logic [2:0] ct, input logic [31:0] cd,
                     input logic [2:0] ta, input logic [2:0] tgb);
    logic ra, rb;
    logic [31:0] da, db;
    bit ecm, cfire, full;
    int h;
    bus.alloc_valid = av;
    bus.alloc_dest = d;
    bus.alloc_opcode = op;
    bus.alloc_pc = pc;
    bus.cdb_valid = cv;
    bus.cdb_tag = ct;
    bus.cdb_data = cd;
    bus.rd_tag_a = ta;
    bus.rd_tag_b = tgb;
    #1;
    full = q.size() >= 8;
    chk("rob_count", 32'(bus.rob_count), q.size());
    chk("rob_empty", 32'(bus.rob_empty), 32'(q.size() == 0));
    chk("alloc_ready", 32'(bus.alloc_ready), 32'(!full));
    if (!full) chk("alloc_tag", 32'(bus.alloc_tag), nxt % 8);
    exp_rd(ta, cv, ct, cd, ra, da);
    exp_rd(tgb, cv, ct, cd, rb, db);
    chk("rd_ready_a", 32'(bus.rd_ready_a), 32'(ra));
    chk("rd_data_a", bus.rd_data_a, da);
    chk("rd_ready_b", 32'(bus.rd_ready_b), 32'(rb));
    chk("rd_data_b", bus.rd_data_b, db);
    ecm = q.size() > 0 && done[q[0]];
    h = ecm ? q[0] : 0;
    cfire = cv && busy[ct] && !done[ct];
    @(posedge clk1);
    #1;
    chk("commit_valid", 32'(bus.commit_valid), 32'(ecm));
    if (ecm) begin
      chk("commit_tag", 32'(bus.commit_tag), h);
      chk("commit_dest", 32'(bus.commit_dest), 32'(dest[h]));
      chk("commit_data", bus.commit_data, data[h]);
      chk("commit_opcode", 32'(bus.commit_opcode), 32'(opc[h]));
      chk("commit_pc", 32'(bus.commit_pc), 32'(pcs[h]));
      busy[h] = 0;
      done[h] = 0;
      void'(q.pop_front());
    end
    if (cfire) begin
      done[ct] = 1;
      data[ct] = cd;
    end
    if (av && !full) begin
      h = nxt % 8;
      busy[h] = 1;
      done[h] = 0;
      dest[h] = d;
      opc[h] = op;
      pcs[h] = pc;
      q.push_back(h);
      nxt++;
    end
  endtask
  task automatic alloc(input logic [4:0] d);
    cyc(1, d, 7'($urandom), 7'($urandom), 0, 0, 0, 0, 0);
  endtask
  task automatic cdb(input logic [2:0] t, input logic [31:0] v);
    cyc(0, 0, 0, 0, 1, t, v, t, 0);
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 3'($urandom), 3'($urandom));
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    bus.alloc_valid = 0;
    bus.cdb_valid = 0;
    bus.rd_tag_a = 0;
    bus.rd_tag_b = 0;
    #1;
    model_clear();
    chk("rst_commit_valid", 32'(bus.commit_valid), 0);
    chk("rst_rob_count", 32'(bus.rob_count), 0);
    chk("rst_rob_empty", 32'(bus.rob_empty), 1);
    chk("rst_alloc_ready", 32'(bus.alloc_ready), 1);
    chk("rst_rd_data_a", bus.rd_data_a, 0);
    @(posedge clk1);
    #1;
    rst_n = 1'b1;
  endtask
  initial begin
    bus.alloc_valid = 0;
    bus.alloc_dest = 0;
    bus.alloc_opcode = 0;
    bus.alloc_pc = 0;
    bus.cdb_valid = 0;
    bus.cdb_tag = 0;
    bus.cdb_data = 0;
    bus.rd_tag_a = 0;
    bus.rd_tag_b = 0;
    @(posedge clk1);
    #1;
    do_reset();
    alloc(5);
    alloc(6);
    alloc(7);
    cdb(2, 32'h30);
    cdb(0, 32'h10);
    cdb(1, 32'h20);
    idle(4);
    cdb(3, 32'h99);
    do_reset();
    for (int i = 0; i < 9; i++) alloc(5'(i));
    cdb(0, 32'h77);
    idle(2);
    alloc(9);
    do_reset();
    for (int i = 0; i < 3; i++) alloc(5'(i));
    cyc(1, 3, 0, 0, 1, 0, 32'h44, 0, 0);
    cyc(1, 4, 0, 0, 0, 0, 0, 4, 0);
    idle(1);
    do_reset();
    alloc(0);
    alloc(1);
    cdb(6, 32'hDEAD);
    cdb(1, 32'h111);
    cdb(1, 32'h222);
    cdb(0, 32'h5);
    idle(4);
    do_reset();
    for (int i = 0; i < 4; i++) alloc(5'(i + 1));
    cyc(0, 0, 0, 0, 1, 3, 32'hABCD, 3, 2);
    cyc(0, 0, 0, 0, 0, 0, 0, 3, 2);
    for (int i = 0; i < 400; i++)
      cyc($urandom_range(0, 2) != 0, 5'($urandom), 7'($urandom), 7'($urandom), $urandom_range(0, 1) == 1,
          3'($urandom), $urandom, 3'($urandom), 3'($urandom));
    do_reset();
    idle(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
